// File: rtl/mem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_loader
// Description : Boot loader that turns a byte stream into IMEM/DMEM word
//               writes and holds the core in reset until a GO byte arrives.
//               Define MEM_LOADER_CHECKSUM_EN for per-frame trailing checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_loader #(
    parameter int IMEM_SIZE_IN_BYTES = 2048,
    parameter int DMEM_SIZE_IN_BYTES = 2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic        wr_sel,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        core_reset,
    output logic        done,
    output logic        error
);

    localparam logic [16:0] c_imem_words = 17'(IMEM_SIZE_IN_BYTES / 4);
    localparam logic [16:0] c_dmem_words = 17'(DMEM_SIZE_IN_BYTES / 4);
    localparam logic [7:0]  c_cmd_imem   = 8'h49;
    localparam logic [7:0]  c_cmd_dmem   = 8'h44;
    localparam logic [7:0]  c_cmd_go     = 8'h47;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR0,
        S_ADDR1,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
        S_RUN,
        S_ERROR
`ifdef MEM_LOADER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_sel;
    logic [15:0] r_index;
    logic [15:0] r_count;
    logic [7:0]  r_len_lo;
    logic [1:0]  r_byte_cnt;
    logic [23:0] r_word;
    logic [15:0] r_wr_index;
    logic [31:0] r_wr_data;

    logic        w_accept;
    logic [15:0] w_len;
    logic [16:0] w_end;
    logic [16:0] w_depth;
    logic        w_range_ok;

    assign w_accept   = in_valid && in_ready;
    assign w_len      = {in_data, r_len_lo};
    // 17-bit sum so a start index near 0xFFFF cannot wrap past the check
    assign w_end      = {1'b0, r_index} + {1'b0, w_len};
    assign w_depth    = r_sel ? c_dmem_words : c_imem_words;
    assign w_range_ok = (w_end <= w_depth);

`ifdef MEM_LOADER_CHECKSUM_EN
    logic [7:0]  r_sum;
    logic [7:0]  w_sum_next;
    assign w_sum_next = r_sum + in_data;
    localparam state_t c_frame_end = S_CSUM;
`else
    localparam state_t c_frame_end = S_IDLE;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (in_data == c_cmd_imem || in_data == c_cmd_dmem) begin
                        w_next = S_ADDR0;
                    end else if (in_data == c_cmd_go) begin
                        w_next = S_RUN;
                    end else begin
                        w_next = S_ERROR;
                    end
                end
            end
            S_ADDR0: if (w_accept) w_next = S_ADDR1;
            S_ADDR1: if (w_accept) w_next = S_LEN0;
            S_LEN0:  if (w_accept) w_next = S_LEN1;
            S_LEN1: begin
                if (w_accept) begin
                    if (!w_range_ok) begin
                        w_next = S_ERROR;
                    end else if (w_len == 16'd0) begin
                        w_next = c_frame_end;
                    end else begin
                        w_next = S_DATA;
                    end
                end
            end
            S_DATA:  if (w_accept && r_byte_cnt == 2'd3) w_next = S_WRITE;
            S_WRITE: w_next = (r_count != 16'd1) ? S_DATA : c_frame_end;
`ifdef MEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (w_accept) begin
                    w_next = (w_sum_next == 8'h00) ? S_IDLE : S_ERROR;
                end
            end
`endif
            S_RUN:   w_next = S_RUN;
            S_ERROR: w_next = S_ERROR;
            default: w_next = S_ERROR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel      <= 1'b0;
            r_index    <= 16'd0;
            r_count    <= 16'd0;
            r_len_lo   <= 8'd0;
            r_byte_cnt <= 2'd0;
            r_word     <= 24'd0;
            r_wr_index <= 16'd0;
            r_wr_data  <= 32'd0;
`ifdef MEM_LOADER_CHECKSUM_EN
            r_sum      <= 8'd0;
`endif
        end else if (r_state == S_WRITE) begin
            r_index <= r_index + 16'd1;
            r_count <= r_count - 16'd1;
        end else if (w_accept) begin
`ifdef MEM_LOADER_CHECKSUM_EN
            r_sum <= (r_state == S_IDLE) ? in_data : w_sum_next;
`endif
            case (r_state)
                S_IDLE: begin
                    if (in_data == c_cmd_imem || in_data == c_cmd_dmem) begin
                        r_sel <= (in_data == c_cmd_dmem);
                    end
                end
                S_ADDR0: r_index[7:0]  <= in_data;
                S_ADDR1: r_index[15:8] <= in_data;
                S_LEN0:  r_len_lo      <= in_data;
                S_LEN1: begin
                    r_count    <= w_len;
                    r_byte_cnt <= 2'd0;
                end
                S_DATA: begin
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                    case (r_byte_cnt)
                        2'd0: r_word[7:0]   <= in_data;
                        2'd1: r_word[15:8]  <= in_data;
                        2'd2: r_word[23:16] <= in_data;
                        default: begin
                            // Output registers only move when a word completes
                            r_wr_data  <= {in_data, r_word};
                            r_wr_index <= r_index;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (r_state != S_WRITE);
    assign wr_en      = (r_state == S_WRITE);
    assign wr_sel     = r_sel;
    assign wr_addr    = {14'd0, r_wr_index, 2'b00};
    assign wr_data    = r_wr_data;
    assign core_reset = (r_state != S_RUN);
    assign done       = (r_state == S_RUN);
    assign error      = (r_state == S_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_loader
// Description : Self-checking bench for mem_loader (table vectors, corner
//               sequences and randomized frames against a stream-level model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_loader;

    localparam int c_imem_words = 512;
    localparam int c_dmem_words = 512;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic        wr_sel;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        core_reset;
    logic        done;
    logic        error;

    mem_loader dut (
        .clk        (clk),
        .reset      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int          n;
        logic [191:0] b;
        int          nw;
        logic        fsel;
        logic [31:0] faddr;
        logic [31:0] fdata;
        logic        lsel;
        logic [31:0] laddr;
        logic [31:0] ldata;
        logic        err;
        logic        dn;
    } vec_t;

    wr_t        got_q[$];
    wr_t        exp_q[$];
    logic [7:0] stream[$];
    logic       m_err;
    logic       m_done;
    int         n_pass  = 0;
    int         n_total = 0;

`ifdef MEM_LOADER_CHECKSUM_EN
    localparam int c_nv = 4;
`else
    localparam int c_nv = 7;
`endif
    vec_t vt[c_nv];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // in_ready may only drop in the single write cycle
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (wr_en === 1'b1) got_q.push_back('{wr_sel, wr_addr, wr_data});
            chk("in_ready_vs_wr_en", {31'd0, in_ready}, {31'd0, ~wr_en});
        end
    end

    task automatic do_reset();
        in_valid = 1'b0;
        in_data  = 8'h00;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        got_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int tries;
        tries    = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && tries < 8) begin
            @(negedge clk);
            tries++;
        end
        if (in_ready !== 1'b1) chk("handshake_timeout", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
    endtask

    task automatic send_stream(input bit gaps);
        for (int i = 0; i < stream.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            send_byte(stream[i]);
        end
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Parses the whole stream frame by frame and lists the writes it implies
    task automatic model();
        int  p, fs, start, len;
        bit  stop;
        logic [7:0] cmd;
        exp_q.delete();
        m_err  = 1'b0;
        m_done = 1'b0;
        p      = 0;
        stop   = 0;
        while (!stop && p < stream.size()) begin
            cmd = stream[p];
            fs  = p;
            if (cmd == 8'h47) begin
                m_done = 1'b1;
                stop   = 1;
            end else if (cmd != 8'h49 && cmd != 8'h44) begin
                m_err = 1'b1;
                stop  = 1;
            end else if (p + 5 > stream.size()) begin
                stop = 1;
            end else begin
                start = int'(stream[p+1]) + 256 * int'(stream[p+2]);
                len   = int'(stream[p+3]) + 256 * int'(stream[p+4]);
                if (start + len > ((cmd == 8'h44) ? c_dmem_words : c_imem_words)) begin
                    m_err = 1'b1;
                    stop  = 1;
                end else begin
                    p += 5;
                    for (int w = 0; w < len && !stop; w++) begin
                        if (p + 4 > stream.size()) begin
                            stop = 1;
                        end else begin
                            exp_q.push_back('{cmd == 8'h44, 32'((start + w) * 4),
                                {stream[p+3], stream[p+2], stream[p+1], stream[p]}});
                            p += 4;
                        end
                    end
`ifdef MEM_LOADER_CHECKSUM_EN
                    if (!stop) begin
                        if (p >= stream.size()) begin
                            stop = 1;
                        end else begin
                            logic [7:0] s;
                            s = 8'h00;
                            for (int k = fs; k <= p; k++) s = s + stream[k];
                            p++;
                            if (s != 8'h00) begin
                                m_err = 1'b1;
                                stop  = 1;
                            end
                        end
                    end
`endif
                end
            end
        end
    endtask

    initial begin
`ifdef MEM_LOADER_CHECKSUM_EN
        vt[0] = '{11, 192'h440000010001000000BA47, 1, 1'b1, 32'h0, 32'h1, 1'b1, 32'h0, 32'h1, 1'b0, 1'b1};
        vt[1] = '{11, 192'h440000010001000000BB47, 1, 1'b1, 32'h0, 32'h1, 1'b1, 32'h0, 32'h1, 1'b1, 1'b0};
        vt[2] = '{7,  192'h4900000000B747, 0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1};
        vt[3] = '{14, 192'h491400020013000000730010000B, 2, 1'b0, 32'h50, 32'h13, 1'b0, 32'h54, 32'h00100073, 1'b0, 1'b0};
`else
        vt[0] = '{13, 192'h49140002001300000073001000, 2, 1'b0, 32'h50, 32'h13, 1'b0, 32'h54, 32'h00100073, 1'b0, 1'b0};
        vt[1] = '{19, 192'h44FF010100AABBCCDD47490000010011223344, 1, 1'b1, 32'h7FC, 32'hDDCCBBAA, 1'b1, 32'h7FC, 32'hDDCCBBAA, 1'b0, 1'b1};
        vt[2] = '{6,  192'h44FF01020047, 0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0};
        vt[3] = '{2,  192'h5547, 0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0};
        vt[4] = '{6,  192'h490000000047, 0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1};
        vt[5] = '{13, 192'h49FE0102000102030405060708, 2, 1'b0, 32'h7F8, 32'h04030201, 1'b0, 32'h7FC, 32'h08070605, 1'b0, 1'b0};
        vt[6] = '{18, 192'h440500010011111111440500010022222222, 2, 1'b1, 32'h14, 32'h11111111, 1'b1, 32'h14, 32'h22222222, 1'b0, 1'b0};
`endif

        // Reset state
        do_reset();
        chk("rst_core_reset", {31'd0, core_reset}, 32'd1);
        chk("rst_done",       {31'd0, done},       32'd0);
        chk("rst_error",      {31'd0, error},      32'd0);
        chk("rst_in_ready",   {31'd0, in_ready},   32'd1);
        chk("rst_wr_en",      {31'd0, wr_en},      32'd0);
        chk("rst_wr_addr",    wr_addr,             32'd0);
        chk("rst_wr_data",    wr_data,             32'd0);

        // Table vectors
        for (int k = 0; k < c_nv; k++) begin
            do_reset();
            stream.delete();
            for (int i = 0; i < vt[k].n; i++) stream.push_back(vt[k].b[8*(vt[k].n-1-i) +: 8]);
            send_stream(1'b0);
            chk($sformatf("v%0d_nwrites", k), 32'(got_q.size()), 32'(vt[k].nw));
            if (vt[k].nw > 0 && got_q.size() > 0) begin
                chk($sformatf("v%0d_first_sel", k),  {31'd0, got_q[0].sel}, {31'd0, vt[k].fsel});
                chk($sformatf("v%0d_first_addr", k), got_q[0].addr, vt[k].faddr);
                chk($sformatf("v%0d_first_data", k), got_q[0].data, vt[k].fdata);
                chk($sformatf("v%0d_last_sel", k),   {31'd0, got_q[$].sel}, {31'd0, vt[k].lsel});
                chk($sformatf("v%0d_last_addr", k),  got_q[$].addr, vt[k].laddr);
                chk($sformatf("v%0d_last_data", k),  got_q[$].data, vt[k].ldata);
                chk($sformatf("v%0d_hold_addr", k),  wr_addr, vt[k].laddr);
                chk($sformatf("v%0d_hold_data", k),  wr_data, vt[k].ldata);
            end
            chk($sformatf("v%0d_error", k),      {31'd0, error},      {31'd0, vt[k].err});
            chk($sformatf("v%0d_done", k),       {31'd0, done},       {31'd0, vt[k].dn});
            chk($sformatf("v%0d_core_reset", k), {31'd0, core_reset}, {31'd0, ~vt[k].dn});
        end

        // Reset mid-DATA: one full word written, second word half-assembled
        do_reset();
        stream = '{8'h44, 8'h03, 8'h00, 8'h02, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02};
        for (int i = 0; i < stream.size(); i++) send_byte(stream[i]);
        in_valid = 1'b0;
        chk("mid_first_write", 32'(got_q.size()), 32'd1);
        chk("mid_wr_sel_before", {31'd0, wr_sel}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_sel",     {31'd0, wr_sel},     32'd0);
        chk("mid_rst_wr_addr",    wr_addr,             32'd0);
        chk("mid_rst_wr_data",    wr_data,             32'd0);
        chk("mid_rst_wr_en",      {31'd0, wr_en},      32'd0);
        chk("mid_rst_in_ready",   {31'd0, in_ready},   32'd1);
        chk("mid_rst_core_reset", {31'd0, core_reset}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_no_partial_write", 32'(got_q.size()), 32'd1);

        // GO timing: core released on the very edge that accepts 0x47
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'h47;
        chk("go_before_edge", {31'd0, core_reset}, 32'd1);
        @(posedge clk);
        #1;
        chk("go_after_edge_core_reset", {31'd0, core_reset}, 32'd0);
        chk("go_after_edge_done",       {31'd0, done},       32'd1);
        @(negedge clk);
        stream = '{8'h49, 8'h00, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        send_stream(1'b0);
        chk("run_ignores_bytes", 32'(got_q.size()), 32'd0);
        chk("run_in_ready",      {31'd0, in_ready}, 32'd1);

        // Randomized frames against the stream model
        for (int it = 0; it < 14; it++) begin
            int nfr;
            stream.delete();
            nfr = $urandom_range(1, 4);
            for (int f = 0; f < nfr; f++) begin
                int kind;
                kind = $urandom_range(0, 9);
                if (kind == 0) begin
                    logic [7:0] b;
                    do b = 8'($urandom_range(0, 255));
                    while (b == 8'h49 || b == 8'h44 || b == 8'h47);
                    stream.push_back(b);
                end else if (kind == 1) begin
                    stream.push_back(8'h47);
                end else begin
                    logic [7:0] cmd;
                    logic [7:0] cs;
                    int start, len;
                    cmd = ($urandom_range(0, 1) == 1) ? 8'h44 : 8'h49;
                    len = $urandom_range(0, 3);
                    if ($urandom_range(0, 5) == 0) start = 512 - len + 1 + $urandom_range(0, 2);
                    else start = $urandom_range(0, 512 - len);
                    stream.push_back(cmd);
                    stream.push_back(8'(start));
                    stream.push_back(8'(start >> 8));
                    stream.push_back(8'(len));
                    stream.push_back(8'h00);
                    cs = cmd + 8'(start) + 8'(start >> 8) + 8'(len);
                    for (int i = 0; i < 4 * len; i++) begin
                        logic [7:0] d;
                        d = 8'($urandom_range(0, 255));
                        stream.push_back(d);
                        cs = cs + d;
                    end
`ifdef MEM_LOADER_CHECKSUM_EN
                    stream.push_back(8'(0 - cs + (($urandom_range(0, 5) == 0) ? 1 : 0)));
`endif
                end
            end
            do_reset();
            send_stream(1'b1);
            model();
            chk($sformatf("r%0d_nwrites", it), 32'(got_q.size()), 32'(exp_q.size()));
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                chk($sformatf("r%0d_w%0d_sel", it, i),  {31'd0, got_q[i].sel}, {31'd0, exp_q[i].sel});
                chk($sformatf("r%0d_w%0d_addr", it, i), got_q[i].addr, exp_q[i].addr);
                chk($sformatf("r%0d_w%0d_data", it, i), got_q[i].data, exp_q[i].data);
            end
            chk($sformatf("r%0d_error", it),      {31'd0, error},      {31'd0, m_err});
            chk($sformatf("r%0d_done", it),       {31'd0, done},       {31'd0, m_done});
            chk($sformatf("r%0d_core_reset", it), {31'd0, core_reset}, {31'd0, ~m_done});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Boot-time loader that sits upstream of the SoC.
- Receives a byte stream on a valid/ready interface, writes 32-bit words into IMEM or DMEM through a word write port, and holds the processor in reset until a GO command arrives.
- It is the hardware equivalent of preloading imem/dmem before releasing processor reset.

Parameters:
- IMEM_SIZE_IN_BYTES, 2048, IMEM capacity; word range 0..IMEM_SIZE_IN_BYTES/4-1.
- DMEM_SIZE_IN_BYTES, 2048, DMEM capacity; word range 0..DMEM_SIZE_IN_BYTES/4-1.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  stream byte valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- wr_en  output  1  one-cycle memory write strobe.
- wr_sel  output  1  0 = IMEM, 1 = DMEM.
- wr_addr  output  32  byte address, word aligned (word index * 4).
- wr_data  output  32  word to write.
- core_reset  output  1  active-high reset to the processor/SoC.
- done  output  1  GO received; processor released.
- error  output  1  sticky protocol or range error.

Behaviour:
- Handshake and reset:
  - A byte transfers when in_valid && in_ready on a rising clk edge.
  - Reset values: in_ready=1, wr_en=0, wr_sel=0, wr_addr=0, wr_data=0, core_reset=1, done=0, error=0, state IDLE.
  - Reset asserted mid-operation aborts the block immediately, with no partial-word write.
- Frame format (multi-byte fields little-endian):
  - cmd byte, then addr_lo, addr_hi (start word index), then len_lo, len_hi (word count), then 4*len data bytes.
  - Each word is assembled little-endian: the first byte goes to [7:0].
  - cmd 0x49 'I' targets IMEM; cmd 0x44 'D' targets DMEM.
  - cmd 0x47 'G' is a single byte with no fields.
- States:
  - IDLE: wait for cmd.
    - 'I' or 'D' latches wr_sel and goes to ADDR0.
    - 'G' goes to RUN.
    - Any other byte sets error and goes to ERROR.
  - ADDR0, ADDR1, LEN0, LEN1 each accept one byte.
  - End of LEN1, range check: start+len must be <= the selected memory's word depth.
    - Check computed 17 bits wide, no wrap.
    - Failure goes to ERROR.
    - len=0 goes back to IDLE.
    - Otherwise go to DATA.
  - DATA: a 2-bit byte counter assembles the word; the 4th accepted byte moves to WRITE.
  - WRITE: exactly one cycle.
    - in_ready=0, wr_en=1, wr_addr={word_index,2'b00}, wr_data=assembled word.
    - Then word_index increments and the remaining count decrements.
    - Goes to DATA if count>0, else IDLE.
  - Sustained throughput is 4 data bytes per 5 cycles.
  - RUN: core_reset deasserts and done asserts on the clock edge that accepts 'G'.
    - in_ready=1; further bytes are accepted and discarded.
    - Stays in RUN until reset.
  - ERROR: error=1 sticky, core_reset stays 1, in_ready=1, bytes discarded, exit only via reset.
- Multiple I/D frames may precede G; later writes to the same address overwrite earlier ones.
- wr_addr and wr_data hold their last values when wr_en=0.
- wr_en never asserts outside WRITE.

Optional Feature:
- Macro: MEM_LOADER_CHECKSUM_EN.
- With macro defined:
  - Each I/D frame carries one extra trailing byte after the data (after LEN1 when len=0).
  - The trailing byte is the 8-bit two's-complement checksum: the sum of all frame bytes including cmd, fields, data and the checksum itself is 0 mod 256.
  - New state CSUM accepts that byte.
  - Match goes to IDLE; mismatch goes to ERROR.
  - Words already written stay in memory; error flags the frame.
- Without macro: no checksum byte is expected and no CSUM state exists.

Test Plan:
- Reset then idle:
  - core_reset=1, done=0, error=0, in_ready=1, wr_en=0.
  - Asserting reset=0 mid-DATA returns all outputs to reset values.
- Load IMEM, 2 words at index 0x14: stream 49 14 00 02 00 13 00 00 00 73 00 10 00:
  - Two wr_en pulses.
  - wr_sel=0, wr_addr=0x50 data 0x00000013, then wr_addr=0x54 data 0x00100073.
  - in_ready=0 only in each WRITE cycle.
- Load DMEM 1 word at index 0x1FF, then send 47:
  - Write at wr_sel=1, wr_addr=0x7FC.
  - core_reset falls and done rises on the clock edge that accepts the 47 byte.
  - Later bytes are ignored and produce no wr_en.
- Range error: 44 FF 01 02 00:
  - 0x1FF+2 > 512, so error=1 after len_hi and no wr_en.
  - A following 47 keeps core_reset=1.
- Bad command 0x55 in IDLE: error=1, state ERROR. Zero-length frame 49 00 00 00 00 returns to IDLE with no write.
- With MEM_LOADER_CHECKSUM_EN:
  - Frame 44 00 00 01 00 01 00 00 00 + BA (sum 0) completes with error=0.
  - The same frame with BB sets error=1 after the data word is written.
